pipeline_buf: RTL
=================

Name: pipeline_buf

Overview:
- Parametrised multi-entry elastic pipeline buffer with valid/ready handshaking on both sides.
- Generalises the single-entry pipeline register to:
  - DEPTH entries;
  - optional combinational ready pass-through;
  - optional empty fall-through;
  - an occupancy count output.
- Sits between any two pipeline stages (fetch→decode, dispatch→issue, etc.). Breaks timing paths and absorbs backpressure bubbles.
- Synchronous flush discards all contents on a mispredict or exception.

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 2, number of storage entries; must be ≥1. Non-power-of-two values are legal.
- READY_PASS, 1, 1: prv_ready also asserts when full and nxt_ready=1. 0: prv_ready depends only on the full flag, with no combinational path from nxt_ready.
- FALLTHRU, 0, 1: when empty, input appears at the output in the same cycle. 0: minimum latency is 1 cycle.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous discard of all entries.
- prv_valid, input, 1, upstream data valid.
- prv_ready, output, 1, buffer can accept this cycle.
- prv_data, input, WIDTH, upstream payload.
- nxt_valid, output, 1, output data valid.
- nxt_ready, input, 1, downstream accepts.
- nxt_data, output, WIDTH, payload at the head.
- count, output, $clog2(DEPTH+1), number of stored entries (excludes a fall-through beat).

Behaviour:
- Reset (async, on rst rising or while high):
  - head=0, tail=0, count=0; all storage entries cleared to 0.
  - Hence nxt_valid=0, nxt_data=0, prv_ready=1.
- Storage is a circular array indexed by head (read) and tail (write).
- Pointers wrap explicitly: pointer==DEPTH-1 → 0. Do not use a power-of-two mask.
- full = (count==DEPTH); empty = (count==0).
- Definitions:
  - enq = prv_valid && prv_ready.
  - deq = nxt_valid && nxt_ready.
  - bypass = FALLTHRU && empty && prv_valid && nxt_ready.
- Enqueue and dequeue rules:
  - On bypass, the beat goes straight through; storage, pointers and count are unchanged.
  - Otherwise, enq writes prv_data to entry[tail] and tail advances.
  - Otherwise, deq advances head.
- count update: count += (enq && !bypass) − (deq && !bypass). Simultaneous enq+deq leaves count unchanged.
- prv_ready:
  - READY_PASS=1: !full || nxt_ready.
  - READY_PASS=0: !full.
  - prv_ready never depends on prv_valid.
- Full with READY_PASS=1 and nxt_ready=1: dequeue and enqueue occur in the same cycle and count stays DEPTH.
- nxt_valid and nxt_data:
  - !empty: nxt_valid=1, nxt_data=entry[head].
  - FALLTHRU=1 and empty: nxt_valid=prv_valid, nxt_data=prv_data.
  - Else: nxt_valid=0, nxt_data=entry[head] (stale value; undefined for consumers).
- Latency:
  - FALLTHRU=0: 1 cycle from enq to nxt_valid.
  - FALLTHRU=1: 0 cycles when empty.
- Throughput: 1 beat/cycle sustained for any DEPTH when READY_PASS=1. With READY_PASS=0, DEPTH ≥ 2 is needed for full rate.
- Ordering: strict FIFO; no reordering or drops except by flush.
- Flush:
  - Takes priority over enq and deq in the same cycle.
  - Next cycle: head=tail=0, count=0, nxt_valid=0 (unless a FALLTHRU beat is presented that cycle).
  - During the flush cycle, prv_ready and nxt_valid keep their combinational values. Any handshake completing that cycle is treated as consumed and discarded; the upstream must not retry.
  - Storage contents are not cleared by flush.
- Reset mid-stream: all entries are lost immediately (async) and outputs reach reset values within the same cycle.
- Data holds stable: while nxt_valid=1 and nxt_ready=0, nxt_data must not change (except on flush or reset).

Test Plan:
- Fill/drain, WIDTH=8 DEPTH=3 READY_PASS=0 FALLTHRU=0:
  - Stimulus: nxt_ready=0; push 0x11, 0x22, 0x33.
  - Response: count 1,2,3; prv_ready=0 after the third push.
  - Then nxt_ready=1: output 0x11, 0x22, 0x33 on consecutive cycles; count returns to 0; nxt_valid=0.
- Full pass-through, DEPTH=2 READY_PASS=1:
  - Stimulus: with count=2 and nxt_ready=1, push 0xA5.
  - Response: prv_ready=1; head entry leaves; count stays 2; 0xA5 emerges two cycles later.
- Wrap-around, DEPTH=3:
  - Stimulus: random valid/ready, 20 beats with values 0..19.
  - Response: output sequence exactly 0..19; count never exceeds 3; tail wraps at least 5 times.
- Fall-through, FALLTHRU=1:
  - Stimulus: empty buffer; prv_valid=1, prv_data=0x7E, nxt_ready=1.
  - Response: same cycle nxt_valid=1, nxt_data=0x7E; count stays 0.
  - With nxt_ready=0 instead: beat stored, count=1.
- Flush priority:
  - Stimulus: count=2; assert flush with prv_valid=1 and nxt_ready=1.
  - Response: next cycle count=0, nxt_valid=0; the pushed beat never appears.
- Async reset:
  - Stimulus: assert rst mid-cycle with count=2.
  - Response: before the next clk edge, nxt_valid=0, nxt_data=0, count=0, prv_ready=1.

Source files
------------

// File: rtl/pipeline_buf_if.sv
// Valid/ready stream bundle used on both sides of the elastic pipeline buffer.
// The master drives valid and data. The slave drives ready.
interface pipeline_buf_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_buf.sv
// Multi-entry elastic pipeline buffer: a circular store with valid/ready on both sides,
// optional ready pass-through, optional empty fall-through, and a synchronous flush.
module pipeline_buf #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter bit READY_PASS = 1'b1,
  parameter bit FALLTHRU   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  pipeline_buf_if.slave              prv,
  pipeline_buf_if.master             nxt,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty;
  logic prvReady, nxtValid;
  logic enq, deq, bypass;
  logic storeEn, popEn;

  // Explicit wrap, so that non-power-of-two depths index only real entries.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign prvReady = !full || (READY_PASS && nxt.ready);
  assign nxtValid = !empty || (FALLTHRU && prv.valid);

  assign enq     = prv.valid && prvReady;
  assign deq     = nxtValid && nxt.ready;
  assign bypass  = FALLTHRU && empty && prv.valid && nxt.ready;
  assign storeEn = enq && !bypass;
  assign popEn   = deq && !bypass;

  assign prv.ready = prvReady;
  assign nxt.valid = nxtValid;
  assign nxt.data  = (FALLTHRU && empty) ? prv.data : mem_q[head_q];
  assign count_o   = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (storeEn) tail_d = nextPtr(tail_q);
      if (popEn)   head_d = nextPtr(head_q);
      case ({storeEn, popEn})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Flush resets the pointers only; stored payloads are left in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (!flush_i && storeEn) mem_q[tail_q] <= prv.data;
    end
  end

endmodule
